// File: rtl/fwd_hazard_ctrl.sv
// Forwarding-select and load-use hazard controller for a five-stage pipeline.
// Tracks the EX/MA/WB destination registers and registers EX-stage operand selects.
module fwd_hazard_ctrl #(
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   holdIn,
    input  logic                   flushIn,
    input  logic [4:0]             IDrsIn,
    input  logic [4:0]             IDrtIn,
    input  logic                   IDuseRsIn,
    input  logic                   IDuseRtIn,
    input  logic                   IDregWriteIn,
    input  logic [4:0]             IDwriteRegIn,
    input  logic [1:0]             IDresKindIn,
    output logic [2:0]             forward1Out,
    output logic [2:0]             forward2Out,
    output logic                   stallOut,
    output logic [STALL_CNT_W-1:0] stallCntOut,
    output logic [26:0]            dbgShadowOut
);

    typedef struct packed {
        logic       valid;
        logic       reg_write;
        logic [4:0] write_reg;
        logic [1:0] res_kind;
    } shadow_t;

    shadow_t r_ex_s;
    shadow_t r_ma_s;
    shadow_t r_wb_s;
    logic [2:0]             r_fwd1;
    logic [2:0]             r_fwd2;
    logic [STALL_CNT_W-1:0] r_stall_cnt;

    logic [3:0] w_sel1;
    logic [3:0] w_sel2;
    logic       w_stall;
    logic       w_bubble;
    shadow_t    w_id_s;

    // Result bit 3 flags a load-use hazard; bits 2:0 are the mux select.
    function automatic logic [3:0] calc_sel(input logic [4:0] r, input logic use_r,
                                            input shadow_t ex_s, input shadow_t ma_s);
        logic [3:0] res;
        res = 4'd0;
        if (use_r && r != 5'd0) begin
            if (ex_s.valid && ex_s.reg_write && ex_s.write_reg != 5'd0 && ex_s.write_reg == r) begin
                case (ex_s.res_kind)
                    2'd0:    res = 4'b0001;
                    2'd1:    res = 4'b0010;
                    2'd2:    res = 4'b0011;
                    default: res = 4'b1000;
                endcase
            end else if (ma_s.valid && ma_s.reg_write && ma_s.write_reg != 5'd0 &&
                         ma_s.write_reg == r) begin
                res = 4'b0100;
            end
        end
        return res;
    endfunction

    always_comb begin
        w_sel1   = calc_sel(IDrsIn, IDuseRsIn, r_ex_s, r_ma_s);
        w_sel2   = calc_sel(IDrtIn, IDuseRtIn, r_ex_s, r_ma_s);
        w_stall  = (w_sel1[3] | w_sel2[3]) & ~flushIn & ~holdIn;
        w_bubble = w_stall | flushIn;
        w_id_s.valid     = 1'b1;
        w_id_s.reg_write = IDregWriteIn;
        w_id_s.write_reg = IDwriteRegIn;
        w_id_s.res_kind  = IDresKindIn;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ex_s      <= '0;
            r_ma_s      <= '0;
            r_wb_s      <= '0;
            r_fwd1      <= 3'd0;
            r_fwd2      <= 3'd0;
            r_stall_cnt <= '0;
        end else if (!holdIn) begin
            r_wb_s <= r_ma_s;
            r_ma_s <= r_ex_s;
            r_ex_s <= w_bubble ? shadow_t'(0) : w_id_s;
            r_fwd1 <= w_bubble ? 3'd0 : w_sel1[2:0];
            r_fwd2 <= w_bubble ? 3'd0 : w_sel2[2:0];
            if (w_stall && !(&r_stall_cnt))
                r_stall_cnt <= r_stall_cnt + {{(STALL_CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign forward1Out  = r_fwd1;
    assign forward2Out  = r_fwd2;
    assign stallOut     = w_stall;
    assign stallCntOut  = r_stall_cnt;
    assign dbgShadowOut = {r_ex_s, r_ma_s, r_wb_s};

endmodule
